// File: rtl/rn_ds_pkg.sv
// Shared widths and payload layout for rename/dispatch-style pipeline stages.
package rn_ds_pkg;

  localparam int unsigned ALUOP_W = 9;
  localparam int unsigned AREG_W  = 5;
  localparam int unsigned PREG_W  = 6;
  localparam int unsigned IMM_W   = 32;
  localparam int unsigned PC_W    = 32;
  localparam int unsigned LANES   = 2;

  typedef struct packed {
    logic [ALUOP_W-1:0] aluop;
    logic [AREG_W-1:0]  src1;
    logic [AREG_W-1:0]  src2;
    logic [AREG_W-1:0]  rdst;
    logic [PREG_W-1:0]  psrc1;
    logic [PREG_W-1:0]  psrc2;
    logic [PREG_W-1:0]  pdst;
    logic [IMM_W-1:0]   imm;
  } lane_payload_t;

  localparam int unsigned LANE_PAYLOAD_W = $bits(lane_payload_t);

  // Group = pc + per-lane valid + per-lane fields.
  function automatic int unsigned group_payload_w(int unsigned lanes, int unsigned aluop_w,
                                                  int unsigned areg_w, int unsigned preg_w,
                                                  int unsigned imm_w, int unsigned pc_w);
    return pc_w + lanes * (1 + aluop_w + 3 * areg_w + 3 * preg_w + imm_w);
  endfunction

  localparam int unsigned PAYLOAD_W =
      group_payload_w(LANES, ALUOP_W, AREG_W, PREG_W, IMM_W, PC_W);

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic 2-entry valid/ready skid register; in_ready_o is a pure register decode.
module pipe_skid_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_data_o
);

  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [Width-1:0] main_data_q, main_data_d;
  logic [Width-1:0] skid_data_q, skid_data_d;
  logic             push, pop;

  assign in_ready_o  = ~skid_valid_q;
  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_data_q;

  assign push = in_valid_i & in_ready_o;
  assign pop  = main_valid_q & out_ready_i;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush_i) begin
      main_valid_d = 1'b0;
      main_data_d  = '0;
      skid_valid_d = 1'b0;
      skid_data_d  = '0;
    end else if (!main_valid_q || pop) begin
      // Head is free this cycle: refill from skid first to keep FIFO order.
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = push;
        if (push) begin
          main_data_d = in_data_i;
        end
      end
    end else if (push) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/rn_ds_pipe.sv
// Rename-to-dispatch pipeline register: skid-buffered handshake, flush, empty-group drop
// and a saturating backpressure counter.
module rn_ds_pipe
  import rn_ds_pkg::*;
#(
  parameter int unsigned LANES   = 2,
  parameter int unsigned ALUOP_W = rn_ds_pkg::ALUOP_W,
  parameter int unsigned AREG_W  = rn_ds_pkg::AREG_W,
  parameter int unsigned PREG_W  = rn_ds_pkg::PREG_W,
  parameter int unsigned IMM_W   = rn_ds_pkg::IMM_W,
  parameter int unsigned PC_W    = rn_ds_pkg::PC_W,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      rn_valid,
  output logic                      rn_ready,
  input  logic [PC_W-1:0]           rn_pc,
  input  logic [LANES-1:0]          rn_lane_valid,
  input  logic [LANES*ALUOP_W-1:0]  rn_aluop,
  input  logic [LANES*AREG_W-1:0]   rn_src1,
  input  logic [LANES*AREG_W-1:0]   rn_src2,
  input  logic [LANES*AREG_W-1:0]   rn_rdst,
  input  logic [LANES*PREG_W-1:0]   rn_psrc1,
  input  logic [LANES*PREG_W-1:0]   rn_psrc2,
  input  logic [LANES*PREG_W-1:0]   rn_pdst,
  input  logic [LANES*IMM_W-1:0]    rn_imm,
  output logic                      ds_valid,
  input  logic                      ds_ready,
  output logic [PC_W-1:0]           ds_pc,
  output logic [LANES-1:0]          ds_lane_valid,
  output logic [LANES*ALUOP_W-1:0]  ds_aluop,
  output logic [LANES*AREG_W-1:0]   ds_src1,
  output logic [LANES*AREG_W-1:0]   ds_src2,
  output logic [LANES*AREG_W-1:0]   ds_rdst,
  output logic [LANES*PREG_W-1:0]   ds_psrc1,
  output logic [LANES*PREG_W-1:0]   ds_psrc2,
  output logic [LANES*PREG_W-1:0]   ds_pdst,
  output logic [LANES*IMM_W-1:0]    ds_imm,
  output logic [CNT_W-1:0]          ds_stall_cnt
);

  localparam int unsigned PayW =
      group_payload_w(LANES, ALUOP_W, AREG_W, PREG_W, IMM_W, PC_W);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [PayW-1:0]  in_data, out_data;
  logic             in_valid;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign in_data = {rn_pc, rn_lane_valid, rn_aluop, rn_src1, rn_src2, rn_rdst,
                    rn_psrc1, rn_psrc2, rn_pdst, rn_imm};

  // Empty groups still see rn_ready, so they are handshaken but never stored.
  assign in_valid = rn_valid & (|rn_lane_valid);

  pipe_skid_reg #(
    .Width (PayW)
  ) u_skid (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (rn_ready),
    .in_data_i   (in_data),
    .out_valid_o (ds_valid),
    .out_ready_i (ds_ready),
    .out_data_o  (out_data)
  );

  assign {ds_pc, ds_lane_valid, ds_aluop, ds_src1, ds_src2, ds_rdst,
          ds_psrc1, ds_psrc2, ds_pdst, ds_imm} = out_data;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (ds_valid && !ds_ready && (stall_cnt_q != CntMax)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ds_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_rn_ds_pipe.sv
// Directed bench for rn_ds_pipe; a second instance with CNT_W=4 covers saturation.
module tb_rn_ds_pipe;

  localparam int BusW = 182;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic rn_valid = 1'b0;
  logic ds_ready = 1'b0;
  logic rn_ready, ds_valid;
  logic [BusW-1:0] rn_bus = '0;
  logic [BusW-1:0] ds_bus;

  logic [31:0] rn_pc, ds_pc;
  logic [1:0]  rn_lv, ds_lv;
  logic [17:0] rn_aluop, ds_aluop;
  logic [9:0]  rn_src1, rn_src2, rn_rdst, ds_src1, ds_src2, ds_rdst;
  logic [11:0] rn_psrc1, rn_psrc2, rn_pdst, ds_psrc1, ds_psrc2, ds_pdst;
  logic [63:0] rn_imm, ds_imm;
  logic [15:0] ds_cnt;

  logic        s_rn_ready, s_ds_valid;
  logic [31:0] s_pc;
  logic [1:0]  s_lv;
  logic [17:0] s_aluop;
  logic [9:0]  s_src1, s_src2, s_rdst;
  logic [11:0] s_psrc1, s_psrc2, s_pdst;
  logic [63:0] s_imm;
  logic [3:0]  s_cnt;

  int checks = 0;
  int errors = 0;

  assign {rn_pc, rn_lv, rn_aluop, rn_src1, rn_src2, rn_rdst,
          rn_psrc1, rn_psrc2, rn_pdst, rn_imm} = rn_bus;
  assign ds_bus = {ds_pc, ds_lv, ds_aluop, ds_src1, ds_src2, ds_rdst,
                   ds_psrc1, ds_psrc2, ds_pdst, ds_imm};

  always #5 clk = ~clk;

  rn_ds_pipe dut (
    .clk (clk), .rst_n (rst_n), .flush (flush),
    .rn_valid (rn_valid), .rn_ready (rn_ready),
    .rn_pc (rn_pc), .rn_lane_valid (rn_lv), .rn_aluop (rn_aluop),
    .rn_src1 (rn_src1), .rn_src2 (rn_src2), .rn_rdst (rn_rdst),
    .rn_psrc1 (rn_psrc1), .rn_psrc2 (rn_psrc2), .rn_pdst (rn_pdst), .rn_imm (rn_imm),
    .ds_valid (ds_valid), .ds_ready (ds_ready),
    .ds_pc (ds_pc), .ds_lane_valid (ds_lv), .ds_aluop (ds_aluop),
    .ds_src1 (ds_src1), .ds_src2 (ds_src2), .ds_rdst (ds_rdst),
    .ds_psrc1 (ds_psrc1), .ds_psrc2 (ds_psrc2), .ds_pdst (ds_pdst), .ds_imm (ds_imm),
    .ds_stall_cnt (ds_cnt)
  );

  rn_ds_pipe #(.CNT_W (4)) dut_sat (
    .clk (clk), .rst_n (rst_n), .flush (flush),
    .rn_valid (rn_valid), .rn_ready (s_rn_ready),
    .rn_pc (rn_pc), .rn_lane_valid (rn_lv), .rn_aluop (rn_aluop),
    .rn_src1 (rn_src1), .rn_src2 (rn_src2), .rn_rdst (rn_rdst),
    .rn_psrc1 (rn_psrc1), .rn_psrc2 (rn_psrc2), .rn_pdst (rn_pdst), .rn_imm (rn_imm),
    .ds_valid (s_ds_valid), .ds_ready (ds_ready),
    .ds_pc (s_pc), .ds_lane_valid (s_lv), .ds_aluop (s_aluop),
    .ds_src1 (s_src1), .ds_src2 (s_src2), .ds_rdst (s_rdst),
    .ds_psrc1 (s_psrc1), .ds_psrc2 (s_psrc2), .ds_pdst (s_pdst), .ds_imm (s_imm),
    .ds_stall_cnt (s_cnt)
  );

  // Distinct, non-empty group number n.
  function automatic logic [BusW-1:0] mk(int n);
    logic [1:0] lv;
    lv = (n % 3 == 0) ? 2'b01 : 2'b11;
    return {32'(32'h1000 + n * 16), lv, 18'(n * 37 + 1), 10'(n * 3 + 2), 10'(n * 5 + 1),
            10'(n + 9), 12'(n * 11), 12'(n * 13 + 4), 12'(n + 7),
            32'(32'hA500_0000 + n), 32'(32'h5A00_0000 ^ n)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    rn_valid = 1'b0;
    ds_ready = 1'b0;
    rn_bus = '0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (ds_valid !== 1'b0) begin
      errors++; $display("FAIL reset_ds_valid got %b exp 0", ds_valid);
    end
    checks++;
    if (ds_bus !== '0) begin
      errors++; $display("FAIL reset_payload got %h exp 0", ds_bus);
    end
    checks++;
    if (ds_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_stall_cnt got %0d exp 0", ds_cnt);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (rn_ready !== 1'b1) begin
      errors++; $display("FAIL reset_rn_ready got %b exp 1", rn_ready);
    end
  endtask

  task automatic test_pass_through();
    logic [BusW-1:0] exp;
    ds_ready = 1'b1;
    exp = {32'h100, 2'b11, 9'h022, 9'h011, 5'd2, 5'd1, 5'd4, 5'd3, 5'd6, 5'd5,
           6'd8, 6'd7, 6'd10, 6'd9, 6'd9, 6'd5, 32'hDEADBEEF, 32'h0000_0042};
    rn_bus = exp;
    rn_valid = 1'b1;
    tick();
    rn_valid = 1'b0;
    checks++;
    if (ds_valid !== 1'b1 || ds_bus !== exp) begin
      errors++; $display("FAIL pass_first got v=%b %h exp v=1 %h", ds_valid, ds_bus, exp);
    end
    checks++;
    if (ds_pdst[5:0] !== 6'd5 || ds_imm[63:32] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL pass_fields got pdst0=%0d imm1=%h exp 5 deadbeef",
                         ds_pdst[5:0], ds_imm[63:32]);
    end
    for (int k = 0; k < 8; k++) begin
      rn_bus = mk(k + 1);
      rn_valid = 1'b1;
      checks++;
      if (rn_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_ready[%0d] got %b exp 1", k, rn_ready);
      end
      tick();
      checks++;
      if (ds_valid !== 1'b1 || ds_bus !== mk(k + 1)) begin
        errors++; $display("FAIL b2b_data[%0d] got v=%b %h exp v=1 %h",
                           k, ds_valid, ds_bus, mk(k + 1));
      end
    end
    rn_valid = 1'b0;
    tick();
    checks++;
    if (ds_valid !== 1'b0 || ds_cnt !== 16'd0) begin
      errors++; $display("FAIL pass_drain got v=%b cnt=%0d exp v=0 cnt=0", ds_valid, ds_cnt);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ds_ready = 1'b0;
    rn_bus = mk(20);
    rn_valid = 1'b1;
    tick();
    checks++;
    if (ds_bus !== mk(20) || rn_ready !== 1'b1 || ds_cnt !== 16'd0) begin
      errors++; $display("FAIL bp_load_a got %h rdy=%b cnt=%0d exp %h rdy=1 cnt=0",
                         ds_bus, rn_ready, ds_cnt, mk(20));
    end
    rn_bus = mk(21);
    tick();
    checks++;
    if (ds_bus !== mk(20) || rn_ready !== 1'b0 || ds_cnt !== 16'd1) begin
      errors++; $display("FAIL bp_skid_b got %h rdy=%b cnt=%0d exp %h rdy=0 cnt=1",
                         ds_bus, rn_ready, ds_cnt, mk(20));
    end
    rn_bus = mk(22);
    tick();
    tick();
    checks++;
    if (ds_valid !== 1'b1 || ds_bus !== mk(20) || ds_cnt !== 16'd3) begin
      errors++; $display("FAIL bp_hold got v=%b %h cnt=%0d exp v=1 %h cnt=3",
                         ds_valid, ds_bus, ds_cnt, mk(20));
    end
    ds_ready = 1'b1;
    tick();
    checks++;
    if (ds_bus !== mk(21) || rn_ready !== 1'b1 || ds_cnt !== 16'd3) begin
      errors++; $display("FAIL bp_b_out got %h rdy=%b cnt=%0d exp %h rdy=1 cnt=3",
                         ds_bus, rn_ready, ds_cnt, mk(21));
    end
    tick();
    rn_valid = 1'b0;
    checks++;
    if (ds_valid !== 1'b1 || ds_bus !== mk(22)) begin
      errors++; $display("FAIL bp_c_out got v=%b %h exp v=1 %h", ds_valid, ds_bus, mk(22));
    end
    tick();
    checks++;
    if (ds_valid !== 1'b0) begin
      errors++; $display("FAIL bp_empty got %b exp 0", ds_valid);
    end
  endtask

  task automatic test_empty_drop();
    ds_ready = 1'b1;
    rn_bus = mk(30);
    rn_bus[149:148] = 2'b00;
    rn_valid = 1'b1;
    checks++;
    if (rn_ready !== 1'b1) begin
      errors++; $display("FAIL drop_ready got %b exp 1", rn_ready);
    end
    tick();
    checks++;
    if (ds_valid !== 1'b0) begin
      errors++; $display("FAIL drop_idle got %b exp 0", ds_valid);
    end
    ds_ready = 1'b0;
    rn_bus = mk(31);
    tick();
    rn_bus = mk(32);
    rn_bus[149:148] = 2'b00;
    tick();
    rn_valid = 1'b0;
    checks++;
    if (rn_ready !== 1'b1 || ds_bus !== mk(31)) begin
      errors++; $display("FAIL drop_no_skid got rdy=%b %h exp rdy=1 %h",
                         rn_ready, ds_bus, mk(31));
    end
    ds_ready = 1'b1;
    tick();
    checks++;
    if (ds_valid !== 1'b0) begin
      errors++; $display("FAIL drop_drain got %b exp 0", ds_valid);
    end
  endtask

  task automatic test_flush();
    do_reset();
    rn_bus = mk(40);
    rn_valid = 1'b1;
    tick();
    rn_bus = mk(41);
    tick();
    flush = 1'b1;
    rn_bus = mk(42);
    tick();
    flush = 1'b0;
    rn_valid = 1'b0;
    checks++;
    if (ds_valid !== 1'b0 || rn_ready !== 1'b1 || ds_bus !== '0) begin
      errors++; $display("FAIL flush_full got v=%b rdy=%b %h exp v=0 rdy=1 0",
                         ds_valid, rn_ready, ds_bus);
    end
    checks++;
    if (ds_cnt !== 16'd2) begin
      errors++; $display("FAIL flush_cnt got %0d exp 2", ds_cnt);
    end
    tick();
    checks++;
    if (ds_valid !== 1'b0) begin
      errors++; $display("FAIL flush_ghost got %b exp 0", ds_valid);
    end
    rn_bus = mk(43);
    rn_valid = 1'b1;
    tick();
    flush = 1'b1;
    rn_bus = mk(44);
    checks++;
    if (rn_ready !== 1'b1) begin
      errors++; $display("FAIL flush_pre_ready got %b exp 1", rn_ready);
    end
    tick();
    flush = 1'b0;
    rn_valid = 1'b0;
    tick();
    checks++;
    if (ds_valid !== 1'b0 || ds_bus !== '0) begin
      errors++; $display("FAIL flush_discard got v=%b %h exp v=0 0", ds_valid, ds_bus);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    rn_bus = mk(50);
    rn_valid = 1'b1;
    tick();
    rn_valid = 1'b0;
    repeat (37) @(posedge clk);
    #1;
    checks++;
    if (ds_cnt !== 16'd37 || ds_valid !== 1'b1) begin
      errors++; $display("FAIL stall_37 got cnt=%0d v=%b exp cnt=37 v=1", ds_cnt, ds_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ds_valid !== 1'b0 || ds_cnt !== 16'd0 || ds_bus !== '0) begin
      errors++; $display("FAIL async_reset got v=%b cnt=%0d %h exp all 0",
                         ds_valid, ds_cnt, ds_bus);
    end
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    rn_bus = mk(60);
    rn_valid = 1'b1;
    tick();
    rn_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (s_cnt !== 4'd15) begin
      errors++; $display("FAIL sat_cnt got %0d exp 15", s_cnt);
    end
    checks++;
    if (ds_cnt !== 16'd20) begin
      errors++; $display("FAIL wide_cnt got %0d exp 20", ds_cnt);
    end
    tick();
    checks++;
    if (s_cnt !== 4'd15 || s_ds_valid !== 1'b1) begin
      errors++; $display("FAIL sat_hold got cnt=%0d v=%b exp cnt=15 v=1", s_cnt, s_ds_valid);
    end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_backpressure();
    test_empty_drop();
    test_flush();
    test_async_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rn_ds_pipe.md
Name: rn_ds_pipe

Overview:
- Parametrised rename-to-dispatch pipeline register for an N-wide superscalar front end.
- Replaces the fixed 2-lane stall-held register with a valid/ready handshake and a 2-entry skid buffer, so `rn_ready` is fully registered and does not depend combinationally on `ds_ready`.
- Adds flush, dropping of groups with no valid lane, and a saturating backpressure counter.
- Sits between the rename stage (producer) and the dispatch stage (consumer).

Parameters:
- LANES, 2, instructions per group.
- ALUOP_W, 9, ALU opcode width per lane.
- AREG_W, 5, architectural register index width.
- PREG_W, 6, physical register index width.
- IMM_W, 32, immediate width per lane.
- PC_W, 32, group PC width.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous squash of all buffered groups.
- rn_valid  in  1  rename presents a group.
- rn_ready  out  1  block accepts a group this cycle.
- rn_pc  in  PC_W  group PC.
- rn_lane_valid  in  LANES  per-lane valid.
- rn_aluop  in  LANES*ALUOP_W  per-lane opcode; lane i occupies bits [i*ALUOP_W +: ALUOP_W]. All packed lane buses below use the same layout.
- rn_src1, rn_src2, rn_rdst  in  LANES*AREG_W each  architectural sources and destination.
- rn_psrc1, rn_psrc2, rn_pdst  in  LANES*PREG_W each  renamed physical sources and destination.
- rn_imm  in  LANES*IMM_W  immediates.
- ds_valid  out  1  group available to dispatch.
- ds_ready  in  1  dispatch consumes the group.
- ds_pc, ds_lane_valid, ds_aluop, ds_src1, ds_src2, ds_rdst, ds_psrc1, ds_psrc2, ds_pdst, ds_imm  out  same widths as the rn_ counterparts; payload of the head entry.
- ds_stall_cnt  out  CNT_W  saturating count of backpressure cycles.

Behaviour:
- Storage is two entries, main (head, drives ds_*) and skid. Each entry holds a valid bit plus the full payload.
- Reset (rst_n low, asynchronous):
  - both entry valids 0, all payload registers 0;
  - ds_valid=0, all ds_* outputs 0, ds_stall_cnt=0;
  - rn_ready=1 from the first edge after release.
- rn_ready = !skid_valid. It is a direct register decode with no combinational path from ds_ready or flush.
- push = rn_valid & rn_ready & |rn_lane_valid.
  - A group with rn_valid=1 and rn_lane_valid=0 is handshaken (consumed) but never stored.
- pop = ds_valid & ds_ready. ds_valid = main_valid.
- Next state when flush=0:
  - main empty, push: main <= input. ds_valid rises next cycle (1-cycle latency).
  - main full, pop, skid empty, push: main <= input.
  - main full, pop, skid full: main <= skid; skid <= empty. No push is possible because rn_ready=0.
  - main full, no pop, push: skid <= input, so rn_ready drops next cycle.
  - main full, pop, no push, skid empty: main <= empty.
- Order is strict FIFO; groups are never reordered or merged. Lane payloads pass through bit-exact.
- Sustained throughput is 1 group/cycle while ds_ready=1.
- A held group on ds_* stays stable while ds_valid=1 and ds_ready=0.
- Flush (synchronous; highest priority below reset):
  - both valids <= 0; input in the same cycle is discarded even though rn_ready may be 1;
  - payload registers are zeroed;
  - ds_valid=0 and rn_ready=1 on the next cycle.
  - A pop coincident with flush is still regarded as taken by dispatch; dispatch also sees flush and ignores it.
- ds_stall_cnt increments by 1 each cycle with ds_valid=1 and ds_ready=0.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset; unaffected by flush.
- Reset asserted mid-operation clears everything immediately, independent of clk.

Decomposition:
- Shared package rn_ds_pkg holds:
  - default widths (ALUOP_W, AREG_W, PREG_W, IMM_W, PC_W);
  - the per-lane payload record typedef;
  - the total payload width constant, used by this block and by any future RN/DS-style stages.
- One natural sub-module, pipe_skid_reg: a generic 2-entry valid/ready skid register parametrised on payload width, with flush.
  - rn_ds_pipe packs pc, lane_valid and all lane fields into one vector, instantiates pipe_skid_reg, then unpacks.
  - The stall counter and the empty-group drop live in rn_ds_pipe.

Test Plan:
- Reset/pass-through: release reset with ds_ready=1; push pc=0x100, lane_valid=2'b11, lane0 pdst=6'd5, lane1 imm=0xDEADBEEF -> next cycle ds_valid=1 with identical payload; rn_ready stays 1; 1 group/cycle over 8 back-to-back groups.
- Backpressure/skid: ds_ready=0, push groups A, B -> rn_ready=0 after B; ds shows A; ds_stall_cnt counts up. Raise ds_ready -> A then B emerge, rn_ready returns 1 once skid drains; third group C offered during stall is not lost.
- Empty group drop: rn_valid=1, rn_lane_valid=0 -> rn_ready=1, ds_valid stays 0, no entry consumed.
- Flush with both entries full plus simultaneous push -> next cycle ds_valid=0, rn_ready=1, ds_* payload 0; the pushed group never appears.
- Async reset mid-stall: assert rst_n=0 between edges with ds_stall_cnt=37 -> ds_valid, ds_stall_cnt and all ds_* go to 0 immediately.
- Saturation with CNT_W=4: hold ds_valid=1, ds_ready=0 for 20 cycles -> ds_stall_cnt=15.
